// File: rtl/spi_word_master.sv
// spi_word_master: SPI mode-3 controller that shifts one or two 16-bit words under a single chip select.
//   CLK/NRST            : system clock, asynchronous active-low reset
//   start, two_word     : frame request and frame length (sampled in IDLE)
//   tx_word0/tx_word1   : words sent MSB first, captured when start is accepted
//   busy/done           : frame in progress / one-cycle end-of-frame pulse
//   rx_word0/rx_word1   : words received on POCI
//   CS/SCK/PICO/POCI    : SPI pins (CS active low, SCK idles high)
//   SPI_WORD_MASTER_IRQ_EN adds irq_clr input and sticky irq output.
`timescale 1ns/1ps
module spi_word_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        start,
    input  logic        two_word,
    input  logic [15:0] tx_word0,
    input  logic [15:0] tx_word1,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_word0,
    output logic [15:0] rx_word1,
`ifdef SPI_WORD_MASTER_IRQ_EN
    input  logic        irq_clr,
    output logic        irq,
`endif
    output logic        CS,
    output logic        SCK,
    output logic        PICO,
    input  logic        POCI
);
    localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SCK_LO = 3'd2, SCK_HI = 3'd3, HOLD = 3'd4, GAP = 3'd5;
    localparam logic [8:0] PH_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);
    logic [2:0]  state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        word_q, word_d, two_q, two_d;
    logic [15:0] tx1_q, tx1_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx0_q, rx0_d, rx1_q, rx1_d;
    logic        cs_q, cs_d, sck_q, sck_d, busy_q, busy_d, done_q, done_d;
    logic        phase_end;
    assign phase_end = cnt_q == ((state_q == GAP) ? GAP_LAST : PH_LAST);
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        word_d  = word_q;
        two_d   = two_q;
        tx1_d   = tx1_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        rx0_d   = rx0_q;
        rx1_d   = rx1_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = (state_q == IDLE || phase_end) ? 9'd0 : cnt_q + 9'd1;
        case (state_q)
            IDLE: if (start) begin
                state_d = SETUP;
                cs_d    = 1'b0;
                busy_d  = 1'b1;
                tx_sh_d = tx_word0;
                tx1_d   = tx_word1;
                two_d   = two_word;
                bit_d   = 4'd0;
                word_d  = 1'b0;
            end
            SETUP: if (phase_end) begin
                state_d = SCK_LO;
                sck_d   = 1'b0;
            end
            SCK_LO: if (phase_end) begin
                state_d = SCK_HI;
                sck_d   = 1'b1;
                rx_sh_d = {rx_sh_q[14:0], POCI};
            end
            SCK_HI: if (phase_end) begin
                if (bit_q != 4'd15) begin
                    state_d = SCK_LO;
                    sck_d   = 1'b0;
                    tx_sh_d = tx_sh_q << 1;
                    bit_d   = bit_q + 4'd1;
                end else begin
                    rx0_d = word_q ? rx0_q : rx_sh_q;
                    rx1_d = word_q ? rx_sh_q : rx1_q;
                    bit_d = 4'd0;
                    // Second word follows immediately: its leading falling edge is this one.
                    if (!word_q && two_q) begin
                        state_d = SCK_LO;
                        sck_d   = 1'b0;
                        word_d  = 1'b1;
                        tx_sh_d = tx1_q;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: if (phase_end) begin
                state_d = GAP;
                cs_d    = 1'b1;
            end
            GAP: if (phase_end) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                tx_sh_d = 16'd0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= IDLE;
            cnt_q   <= 9'd0;
            bit_q   <= 4'd0;
            word_q  <= 1'b0;
            two_q   <= 1'b0;
            tx1_q   <= 16'd0;
            tx_sh_q <= 16'd0;
            rx_sh_q <= 16'd0;
            rx0_q   <= 16'd0;
            rx1_q   <= 16'd0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            two_q   <= two_d;
            tx1_q   <= tx1_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx0_q   <= rx0_d;
            rx1_q   <= rx1_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
`ifdef SPI_WORD_MASTER_IRQ_EN
    logic irq_q;
    // Setting on both the edge that raises done and the done cycle itself lets set win over a clear seen with done.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) irq_q <= 1'b0;
        else       irq_q <= done_d | done_q | (irq_q & ~irq_clr);
    end
    assign irq = irq_q;
`endif
    assign CS       = cs_q;
    assign SCK      = sck_q;
    assign PICO     = tx_sh_q[15];
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_word0 = rx0_q;
    assign rx_word1 = rx1_q;
endmodule

// File: tb/tb_spi_word_master.sv
// tb_spi_word_master: randomized self-checking bench for spi_word_master with a behavioural SPI peripheral.
`timescale 1ns/1ps
module tb_spi_word_master;
    localparam int H = 2;
    logic        clk = 1'b0, nrst = 1'b1, start = 1'b0, two_word = 1'b0;
    logic [15:0] tx_word0 = 16'd0, tx_word1 = 16'd0;
    logic        busy, done, cs, sck, pico;
    logic        poci = 1'b0;
    logic [15:0] rx_word0, rx_word1;
`ifdef SPI_WORD_MASTER_IRQ_EN
    logic        irq_clr = 1'b0, irq;
    bit          clr_at_done = 1'b0;
`endif
    int          total = 0, bad = 0;
    logic [15:0] tx_buff = 16'd0, m_rx0 = 16'd0, m_rx1 = 16'd0;
    logic [31:0] rx_bits = 32'd0;
    int          rises_total = 0, base = 0, cs_hi_rises = 0;
    always #5 clk = ~clk;
    spi_word_master #(.CLK_DIV(H)) dut (
        .CLK(clk), .NRST(nrst), .start(start), .two_word(two_word),
        .tx_word0(tx_word0), .tx_word1(tx_word1), .busy(busy), .done(done),
        .rx_word0(rx_word0), .rx_word1(rx_word1),
`ifdef SPI_WORD_MASTER_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .CS(cs), .SCK(sck), .PICO(pico), .POCI(poci)
    );
    // Peripheral: reloads tx_buff every 16 bits, drives on falling SCK, samples PICO on rising SCK.
    always @(negedge cs) base = rises_total;
    always @(posedge sck) begin
        if (cs) cs_hi_rises++;
        else begin
            rx_bits = {rx_bits[30:0], pico};
            rises_total++;
        end
    end
    always @(negedge sck) if (!cs) poci = tx_buff[15 - ((rises_total - base) % 16)];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic frame(input logic two, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] bv, input logic junk);
        int lat, nd, r0, h0;
        logic [31:0] exp_bits;
        lat = 0;
        nd  = 0;
        @(negedge clk);
        tx_buff  = bv;
        two_word = two;
        tx_word0 = w0;
        tx_word1 = w1;
        start    = 1'b1;
        r0 = rises_total;
        h0 = cs_hi_rises;
        @(posedge clk);
        #1;
        start    = 1'b0;
        tx_word0 = 16'($urandom);
        tx_word1 = 16'($urandom);
        two_word = 1'($urandom);
        check("busy_on", 32'(busy), 32'd1);
        check("cs_on", 32'(cs), 32'd0);
        check("pico_msb", 32'(pico), 32'(w0[15]));
        for (int k = 1; k <= 400 && (lat == 0 || k < lat + 4); k++) begin
            @(posedge clk);
            #1;
            if (junk) start = (k == 10);
`ifdef SPI_WORD_MASTER_IRQ_EN
            irq_clr = clr_at_done && done;
`endif
            if (done) begin
                nd++;
                if (lat == 0) begin
                    lat = k;
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
        start = 1'b0;
        exp_bits = two ? {w0, w1} : {16'd0, w0};
        m_rx0 = bv;
        if (two) m_rx1 = bv;
        check("latency", 32'(lat), two ? 32'(68 * H) : 32'(36 * H));
        check("done_cnt", 32'(nd), 32'd1);
        check("sck_rises", 32'(rises_total - r0), two ? 32'd32 : 32'd16);
        check("rises_cs_hi", 32'(cs_hi_rises - h0), 32'd0);
        check("pico_bits", two ? rx_bits : {16'd0, rx_bits[15:0]}, exp_bits);
        check("rx0", 32'(rx_word0), 32'(m_rx0));
        check("rx1", 32'(rx_word1), 32'(m_rx1));
        check("idle_pins", 32'({cs, sck, pico, busy}), 32'b1100);
    endtask
    initial begin
        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", 32'({cs, sck, pico, busy, done}), 32'b11000);
        check("rst_rx", {rx_word0, rx_word1}, 32'd0);
`ifdef SPI_WORD_MASTER_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        @(negedge clk);
        nrst = 1'b1;
        frame(1'b0, 16'hA380, 16'h0000, 16'hBEEF, 1'b0);
        check("cmd_byte", 32'(rx_bits[15:8]), 32'hA3);
        check("data_byte", 32'(rx_bits[7:0]), 32'h80);
        frame(1'b0, 16'h0000, 16'h0000, 16'hCAFE, 1'b0);
        begin
            int r0;
            @(negedge clk);
            tx_buff  = 16'h5A5A;
            tx_word0 = 16'($urandom);
            two_word = 1'b1;
            start    = 1'b1;
            r0 = rises_total;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int k = 0; k < 200 && rises_total - r0 < 5; k++) begin
                @(posedge clk);
                #1;
            end
            check("rst_wait", 32'(rises_total - r0), 32'd5);
            nrst = 1'b0;
            #1;
            m_rx0 = 16'd0;
            m_rx1 = 16'd0;
            check("mid_rst_pins", 32'({cs, sck, pico, busy, done}), 32'b11000);
            check("mid_rst_rx0", 32'(rx_word0), 32'(m_rx0));
            check("mid_rst_rx1", 32'(rx_word1), 32'(m_rx1));
            repeat (3) @(posedge clk);
            @(negedge clk);
            nrst = 1'b1;
        end
        frame(1'b0, 16'hA380, 16'h0000, 16'hBEEF, 1'b0);
        check("cmd_after_rst", 32'(rx_bits[15:8]), 32'hA3);
        check("data_after_rst", 32'(rx_bits[7:0]), 32'h80);
        frame(1'b1, 16'h2300, 16'h0000, 16'h1234, 1'b0);
        check("rx_no_x", 32'(^{rx_word0, rx_word1} === 1'bx), 32'd0);
        frame(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        frame(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        for (int i = 0; i < 20; i++)
            frame(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
`ifdef SPI_WORD_MASTER_IRQ_EN
        check("irq_set", 32'(irq), 32'd1);
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", 32'(irq), 32'd0);
        clr_at_done = 1'b1;
        frame(1'b0, 16'($urandom), 16'd0, 16'($urandom), 1'b0);
        check("irq_set_wins", 32'(irq), 32'd1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_word_master.md
SPI_WORD_MASTER -- requirements
Module: spi_word_master

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in CLK cycles (H); legal range 1..255.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 NRST  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  transaction request, sampled in IDLE only.
REQ-005 two_word  input  1  sampled with start: 1 = 32-bit frame (two words under one CS), 0 = single 16-bit word.
REQ-006 tx_word0  input  16  first word to send, MSB first, captured at start acceptance.
REQ-007 tx_word1  input  16  second word to send, captured at start acceptance.
REQ-008 busy  output  1  high from the cycle after start acceptance until done.
REQ-009 done  output  1  one-CLK pulse at transaction end.
REQ-010 rx_word0  output  16  word received on POCI during word 0.
REQ-011 rx_word1  output  16  word received on POCI during word 1.
REQ-012 CS  output  1  active-low chip select to spiCore.
REQ-013 SCK  output  1  SPI clock, mode 3 (idles high).
REQ-014 PICO  output  1  controller-to-peripheral data.
REQ-015 POCI  input  1  peripheral-to-controller data.

Function
REQ-016 States SHALL be IDLE, SETUP, SCK_LO, SCK_HI, HOLD, GAP; every non-IDLE phase lasts exactly H CLK cycles, except GAP, which lasts 2H.
REQ-017 IDLE with start=1: next cycle CS=0, busy=1, state SETUP, PICO=tx_word0[15], and the bit counter and word index cleared.
REQ-018 SETUP->SCK_LO: SCK falls, giving the leading falling edge that spiCore uses to load tx_buff.
REQ-019 SCK_LO->SCK_HI: SCK rises; POCI is shifted into the rx shift register, LSB-in, on that same CLK edge.
REQ-020 SCK_HI->SCK_LO: on bits 1..15 of a word, SCK falls and PICO advances to the next lower bit.
REQ-021 After the 16th rising edge of a word, the rx shift register SHALL be copied to rx_word0 or rx_word1 when the SCK_HI phase ends.
REQ-022 End of word 0 with two_word=1: SCK falls, PICO=tx_word1[15], word 1 begins with no extra gap; CS stays low.
REQ-023 End of last word: state HOLD with SCK=1; then CS=1 and GAP; then done=1 for one cycle, busy=0, IDLE.
REQ-024 Total length from the start-accept edge to the done pulse SHALL be 36H CLK cycles for a single word and 68H CLK cycles for two words.
REQ-025 start while busy SHALL be ignored; tx_word inputs changing mid-frame SHALL have no effect.
REQ-026 In IDLE: CS=1, SCK=1, PICO=0; rx_word outputs hold their last values.
REQ-027 Exactly 16 rising SCK edges per word SHALL occur, and none while CS=1.

Reset
REQ-028 NRST=0 SHALL immediately force CS=1, SCK=1, PICO=0, busy=0, done=0, rx_word0=rx_word1=0 and state IDLE, including mid-frame.
REQ-029 After NRST rises, the first start SHALL behave identically to a start issued after a completed frame.

Configuration
REQ-030 Macro SPI_WORD_MASTER_IRQ_EN: when defined, add input irq_clr and output irq, a sticky flag set by done and cleared by irq_clr, where set wins if both occur in the same cycle and irq resets to 0. When undefined, neither port exists and behaviour is otherwise identical.

Verification
REQ-031 Bench SHALL connect the DUT to spiCore (tx_buff=0xBEEF), with CLK_DIV=2 and a single word; stimulus tx_word0=0xA380 -> after done, cmd_byte=0xA3 and data_byte=0x80.
REQ-032 tx_buff=0xCAFE, tx_word0=0x0000, single word -> rx_word0=0xCAFE; done exactly 72 CLK cycles after start is accepted.
REQ-033 two_word=1, tx_word0=0x2300, tx_word1=0x0000, tx_buff=0x1234 -> 32 rising SCK edges under a single CS low, done at 136 cycles, and rx_word0 and rx_word1 contain no X.
REQ-034 start pulsed again at cycle 10 of an active frame -> no effect; exactly one done pulse; SCK edge count unchanged.
REQ-035 NRST asserted after the 5th rising SCK edge -> CS=1, SCK=1, busy=0 and rx_word0=0 immediately; a following frame with 0xA380 passes as in REQ-031.
REQ-036 With SPI_WORD_MASTER_IRQ_EN defined: irq rises with done and stays high; irq_clr pulse -> irq=0; irq_clr asserted in the same cycle as done -> irq=1.
